// File: rtl/qr_cordic_pkg.sv
// Shared constants and types for the 8x4 CORDIC QR (R-factor) engine.
// No ports: parameters, FSM state enum, word/row typedefs and the load
// conversion helper used by qr_cordic_8x4 and cordic_pair_stage.
package qr_cordic_pkg;
  localparam int LENGTH  = 13;          // external element width, Q4.8
  localparam int ROWS    = 8;
  localparam int COLS    = 4;
  localparam int ITER    = 12;          // micro-rotations per Givens rotation
  localparam int IW      = 20;          // internal width, 12 fractional bits
  localparam int BUS_W   = COLS * LENGTH;
  localparam int K_SCALE = 2487;        // 1/CORDIC gain in Q0.12
  localparam int FRAC_SH = 4;           // internal frac bits minus external frac bits

  localparam int IT_W  = $clog2(ITER);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  localparam logic signed [IW:0] SAT_HI = (IW+1)'(2**(LENGTH-1) - 1);
  localparam logic signed [IW:0] SAT_LO = (IW+1)'(-(2**(LENGTH-1)));

  typedef enum logic [2:0] {
    IDLE, LOAD, ROTATE, SCALE, OUTPUT
  } state_e;

  typedef logic signed [IW-1:0] word_t;
  typedef word_t [COLS-1:0]     row_t;

  // Q4.8 -> internal: sign-extend and move the binary point up 4 bits.
  function automatic word_t load_conv(logic [LENGTH-1:0] e);
    return {{(IW-LENGTH-FRAC_SH){e[LENGTH-1]}}, e, {FRAC_SH{1'b0}}};
  endfunction
endpackage

// File: rtl/cordic_pair_stage.sv
// One combinational CORDIC micro-rotation applied to a row pair.
// Ports: x, y   - input rows (x = upper row, y = row being zeroed)
//        sh     - micro-rotation index i (shift amount)
//        piv    - pivot column whose y element steers the direction
//        xo, yo - rotated rows
module cordic_pair_stage import qr_cordic_pkg::*; (
  input  row_t             x,
  input  row_t             y,
  input  logic [IT_W-1:0]  sh,
  input  logic [COL_W-1:0] piv,
  output row_t             xo,
  output row_t             yo
);
  word_t y_piv;
  logic  neg;

  // Direction is decided once from the pivot column and shared by all lanes
  // so the whole row pair rotates by the same angle.
  assign y_piv = y[piv];
  assign neg   = y_piv[IW-1];

  for (genvar j = 0; j < COLS; j++) begin : g_col
    word_t xj, yj, xs, ys;
    assign xj    = x[j];
    assign yj    = y[j];
    assign xs    = xj >>> sh;
    assign ys    = yj >>> sh;
    assign xo[j] = neg ? xj - ys : xj + ys;
    assign yo[j] = neg ? yj + xs : yj - xs;
  end
endmodule

// File: rtl/qr_cordic_8x4.sv
// 8x4 QR decomposition (R factor only) by CORDIC Givens rotations.
// Loads 8 row beats, runs 22 Givens rotations (ITER micro-rotations plus
// one gain-compensation cycle each), then streams 8 rounded/saturated R rows.
// Ports: clk, rst_n (async active-low)
//        valid, in      - input row beat, column j at in[13j+12:13j]
//        out_vallid,out - output R row beat, same packing
module qr_cordic_8x4 import qr_cordic_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [BUS_W-1:0] in,
  output logic             out_vallid,
  output logic [BUS_W-1:0] out
);
  state_e state_q, state_d;

  row_t [ROWS-1:0]  rows;     // indexed by matrix row (row r = beat 7-r)
  logic [ROW_W-1:0] beat;
  logic [ROW_W-1:0] r_idx;    // row being zeroed (y); x is r_idx-1
  logic [ROW_W-1:0] r_lo;
  logic [COL_W-1:0] c_idx;
  logic [IT_W-1:0]  it;
  logic [ROW_W:0]   k;        // output beat counter, 0..ROWS

  row_t  in_row, x_cur, y_cur, x_pre, y_pre, x_rot, y_rot, x_scl, y_scl, o_row;
  word_t x_piv;
  logic  flip, pair_done, last_pair;
  logic [BUS_W-1:0] o_bus;

  function automatic word_t scale_w(word_t v);
    logic signed [IW+11:0] p;
    p = v * $signed(14'(K_SCALE));
    p = p >>> 12;
    return p[IW-1:0];
  endfunction

  // Round to 8 fractional bits, then clamp into the 13-bit output range.
  function automatic logic [LENGTH-1:0] fmt_w(word_t v);
    logic signed [IW:0] t;
    t = (IW+1)'(v) + (IW+1)'(8);
    t = t >>> FRAC_SH;
    if (t > SAT_HI)      return SAT_HI[LENGTH-1:0];
    else if (t < SAT_LO) return SAT_LO[LENGTH-1:0];
    else                 return t[LENGTH-1:0];
  endfunction

  assign r_lo      = r_idx - ROW_W'(1);
  assign x_cur     = rows[r_lo];
  assign y_cur     = rows[r_idx];
  assign x_piv     = x_cur[c_idx];
  // Pre-negation is folded into the first micro-rotation cycle so each
  // Givens rotation costs exactly ITER+1 cycles.
  assign flip      = (it == '0) && x_piv[IW-1];
  assign pair_done = (r_idx == ROW_W'(c_idx) + ROW_W'(1));
  assign last_pair = pair_done && (c_idx == COL_W'(COLS-1));
  assign o_row     = rows[ROW_W'(ROWS-1) - k[ROW_W-1:0]];

  always_comb begin
    in_row = '0;
    o_bus  = '0;
    for (int j = 0; j < COLS; j++) begin
      in_row[j]               = load_conv(in[j*LENGTH +: LENGTH]);
      o_bus[j*LENGTH +: LENGTH] = fmt_w(o_row[j]);
    end
  end

  always_comb begin
    x_pre = x_cur;
    y_pre = y_cur;
    if (flip) begin
      for (int j = 0; j < COLS; j++) begin
        x_pre[j] = -x_cur[j];
        y_pre[j] = -y_cur[j];
      end
    end
  end

  cordic_pair_stage u_stage (
    .x   (x_pre),
    .y   (y_pre),
    .sh  (it),
    .piv (c_idx),
    .xo  (x_rot),
    .yo  (y_rot)
  );

  // Gain compensation; the eliminated element is forced to exact zero since
  // CORDIC only drives it to within a few LSB.
  always_comb begin
    x_scl = '0;
    y_scl = '0;
    for (int j = 0; j < COLS; j++) begin
      x_scl[j] = scale_w(x_cur[j]);
      y_scl[j] = (COL_W'(j) == c_idx) ? '0 : scale_w(y_cur[j]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid) state_d = LOAD;
      LOAD:    if (valid && beat == ROW_W'(ROWS-1)) state_d = ROTATE;
      ROTATE:  if (it == IT_W'(ITER-1)) state_d = SCALE;
      SCALE:   state_d = last_pair ? OUTPUT : ROTATE;
      OUTPUT:  if (k == (ROW_W+1)'(ROWS)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows       <= '0;
      beat       <= '0;
      r_idx      <= ROW_W'(ROWS-1);
      c_idx      <= '0;
      it         <= '0;
      k          <= '0;
      out        <= '0;
      out_vallid <= 1'b0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (state_q == IDLE) begin
            r_idx <= ROW_W'(ROWS-1);
            c_idx <= '0;
            it    <= '0;
            k     <= '0;
          end
          if (valid) begin
            rows[ROW_W'(ROWS-1) - beat] <= in_row;
            beat                        <= beat + ROW_W'(1);
          end
        end
        ROTATE: begin
          rows[r_lo]  <= x_rot;
          rows[r_idx] <= y_rot;
          it          <= it + IT_W'(1);
        end
        SCALE: begin
          rows[r_lo]  <= x_scl;
          rows[r_idx] <= y_scl;
          it          <= '0;
          if (pair_done) begin
            c_idx <= c_idx + COL_W'(1);
            r_idx <= ROW_W'(ROWS-1);
          end else begin
            r_idx <= r_idx - ROW_W'(1);
          end
        end
        OUTPUT: begin
          if (k < (ROW_W+1)'(ROWS)) begin
            out        <= o_bus;
            out_vallid <= 1'b1;
            k          <= k + (ROW_W+1)'(1);
          end else begin
            out        <= '0;
            out_vallid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_qr_cordic_8x4.sv
module tb_qr_cordic_8x4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [51:0] in = '0;
  logic        out_vallid;
  logic [51:0] out;

  always #5 clk = ~clk;

  qr_cordic_8x4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (valid),
    .in         (in),
    .out_vallid (out_vallid),
    .out        (out)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          beats [8][4];
  logic [51:0] exp_q [8];

  task automatic check(input string tag, input logic [51:0] obs, input logic [51:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic int w20(input longint v);
    logic [19:0] t;
    t = v[19:0];
    return int'($signed(t));
  endfunction

  function automatic logic [51:0] pack_in(input int b);
    logic [51:0] v;
    int t;
    v = '0;
    for (int j = 0; j < 4; j++) begin
      t = beats[b][j];
      v[13*j +: 13] = t[12:0];
    end
    return v;
  endfunction

  // Golden model: plain integer arithmetic on an 8x4 matrix following the
  // Givens/CORDIC recipe, IW-bit wraparound modelled explicitly.
  task automatic build_expected();
    int m [8][4];
    int xr, yr, xs, ys, nx, ny, t;
    logic [51:0] p;
    for (int r = 0; r < 8; r++)
      for (int j = 0; j < 4; j++)
        m[r][j] = beats[7-r][j] * 16;
    for (int c = 0; c < 4; c++) begin
      for (int r = 7; r >= c + 1; r--) begin
        xr = r - 1;
        yr = r;
        if (m[xr][c] < 0)
          for (int j = 0; j < 4; j++) begin
            m[xr][j] = w20(-m[xr][j]);
            m[yr][j] = w20(-m[yr][j]);
          end
        for (int i = 0; i < 12; i++) begin
          bit neg;
          neg = (m[yr][c] < 0);
          for (int j = 0; j < 4; j++) begin
            xs = m[xr][j] >>> i;
            ys = m[yr][j] >>> i;
            if (neg) begin nx = m[xr][j] - ys; ny = m[yr][j] + xs; end
            else     begin nx = m[xr][j] + ys; ny = m[yr][j] - xs; end
            m[xr][j] = w20(nx);
            m[yr][j] = w20(ny);
          end
        end
        for (int j = 0; j < 4; j++) begin
          m[xr][j] = w20((longint'(m[xr][j]) * 2487) >>> 12);
          m[yr][j] = w20((longint'(m[yr][j]) * 2487) >>> 12);
        end
        m[yr][c] = 0;
      end
    end
    for (int k = 0; k < 8; k++) begin
      p = '0;
      for (int j = 0; j < 4; j++) begin
        t = (m[7-k][j] + 8) >>> 4;
        if (t > 4095)  t = 4095;
        if (t < -4096) t = -4096;
        p[13*j +: 13] = t[12:0];
      end
      exp_q[k] = p;
    end
  endtask

  task automatic run_matrix(input string tag, input bit extra);
    int lat;
    build_expected();
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      valid = 1'b1;
      in    = pack_in(b);
    end
    if (extra) begin
      @(negedge clk);
      valid = 1'b1;
      in    = 'x;
    end
    @(negedge clk);
    valid = 1'b0;
    in    = '0;
    lat = 0;
    while (!out_vallid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s_latency_le_400", tag), {51'b0, out_vallid}, 52'd1);
    if (!out_vallid) return;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_vld%0d", tag, k), {51'b0, out_vallid}, 52'd1);
      check($sformatf("%s_row_beat%0d", tag, k), out, exp_q[k]);
      if (k < 7) @(negedge clk);
    end
    @(negedge clk);
    check($sformatf("%s_vld_after", tag), {51'b0, out_vallid}, 52'd0);
    check($sformatf("%s_out_after", tag), out, 52'd0);
  endtask

  task automatic set_all(input int v);
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < 4; j++)
        beats[b][j] = v;
  endtask

  task automatic set_random();
    for (int b = 0; b < 8; b++)
      for (int j = 0; j < 4; j++)
        beats[b][j] = int'($urandom_range(8191)) - 4096;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", out, 52'd0);
    check("reset_vld", {51'b0, out_vallid}, 52'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // identity in beats 4..7, zeros in beats 0..3
    set_all(0);
    for (int j = 0; j < 4; j++) beats[7-j][j] = 256;
    run_matrix("identity", 1'b0);

    // single column
    set_all(0);
    for (int b = 0; b < 8; b++) beats[b][0] = 256;
    run_matrix("single_col", 1'b0);
    check("single_col_r00", {39'b0, exp_q[7][12:0]}, 52'd724);

    // same matrix with an X ninth beat
    run_matrix("extra_beat", 1'b1);

    // negative pivots and saturation
    set_all(-4096);
    run_matrix("neg_sat", 1'b0);

    // random matrices, back to back
    for (int n = 0; n < 3; n++) begin
      set_random();
      run_matrix($sformatf("rand%0d", n), 1'b0);
    end

    // reset in the middle of ROTATE: outputs clear, no window follows
    set_random();
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      valid = 1'b1;
      in    = pack_in(b);
    end
    @(negedge clk);
    valid = 1'b0;
    in    = '0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out", out, 52'd0);
    check("midrst_vld", {51'b0, out_vallid}, 52'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hi_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (out_vallid) hi_cnt++;
    end
    check("midrst_no_window", 52'(hi_cnt), 52'd0);

    // recovery after the mid-operation reset
    set_random();
    run_matrix("post_reset", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/qr_cordic_8x4.md
Name: qr_cordic_8x4

Overview:
- Computes the R factor of a QR decomposition of an 8x4 signed fixed-point matrix A using Givens rotations.
- Each Givens rotation is a CORDIC vectoring/rotation pass; no multipliers other than the constant-K scale.
- The block is a standalone accelerator: it loads 8 rows, processes them, then streams 8 rows of R.

Parameters:
- LENGTH, 13: element width; two's complement Q4.8 (sign, 4 integer bits, 8 fractional bits).
- ROWS, 8: matrix rows; one row per input/output beat.
- COLS, 4: matrix columns; the bus width is COLS*LENGTH = 52.
- ITER, 12: CORDIC micro-rotations per Givens rotation.
- IW, 20: internal word width; two's complement with 12 fractional bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid  in  1  qualifies the `in` row beat.
- in  in  52  one row; column j sits at bits [13j+12:13j].
- out_vallid  out  1  output row qualifier (port name spelled exactly so).
- out  out  52  one R row; same column packing as `in`.

Behaviour:
- Reset (asynchronous, any time including mid-operation): out=0, out_vallid=0, FSM to IDLE, row buffer cleared.
- FSM states: IDLE -> LOAD -> ROTATE -> SCALE -> (ROTATE | OUTPUT) -> IDLE.
- IDLE/LOAD:
  - Capture `in` on each rising edge with valid=1, into beats 0..7.
  - After the 8th capture, go to ROTATE.
  - valid beats after the 8th, and any valid during ROTATE/SCALE/OUTPUT, are ignored; `in` may be X there.
- Row indexing: matrix row r = input beat 7-r, so row 0 is the last beat.
- Load conversion: each element is sign-extended to IW and shifted left 4.
- Elimination order: for column c = 0..3, for r = 7 down to c+1, rotate the pair (row r-1 = x, row r = y) to zero A[r][c]. This gives 22 rotations.
- Pre-step of each rotation: if x[c] < 0, negate both rows in every column.
- Micro-rotations, i = 0..ITER-1, applied to all 4 columns in parallel:
  - d = +1 if y[c] < 0, else -1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i).
  - Shifts are arithmetic (floor).
- SCALE (1 cycle):
  - Multiply every element of both rows by K = 2487 (Q0.12) and arithmetic-shift right 12.
  - Force A[r][c] = 0 exactly.
- OUTPUT:
  - Each element is rounded to 8 fractional bits (add 8, then >>>4).
  - The rounded value saturates to [-4096, 4095].
  - out_vallid is high for exactly 8 consecutive cycles.
  - In cycle k of that window (k = 0..7), out carries row 7-k; rows 7..4 are all zero and the last beat is R row 0.
  - out is valid in the same cycle out_vallid first rises.
  - After the window: out_vallid=0, out=0, return to IDLE ready for a new matrix.
- Latency: out_vallid rises no later than 400 cycles after the 8th captured beat (nominal 22*(ITER+1) plus overhead).
- Results are bit-exact against a golden model implementing exactly the arithmetic above.

Decomposition:
- Shared package qr_cordic_pkg holds:
  - LENGTH, ROWS, COLS, ITER, IW;
  - the K constant (2487) and the fractional-shift constant (4);
  - the FSM state enum;
  - a row typedef (COLS x IW).
- One natural sub-module, cordic_pair_stage: a combinational single micro-rotation over a row pair.
  - Inputs: x row, y row, shift amount i, pivot column c.
  - Outputs: x' row and y' row.
- The top level holds the row buffer, the FSM and the scale/round/saturate logic.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles -> out=0 and out_vallid=0; assert rst_n=0 mid-ROTATE -> outputs clear immediately and no output window appears.
- Identity-like matrix:
  - Stimulus: input beats 4..7 form the identity (beat 7 = [256,0,0,0], beat 6 = [0,256,0,0], …); beats 0..3 are zero.
  - Response: output beats 0..3 are zero; the last four beats form an upper-triangular R whose diagonal is within ±2 LSB of 256, matching the golden model exactly.
- Single column:
  - Stimulus: every row [256,0,0,0].
  - Response: R[0][0] = golden value ≈ 724 (√8 in Q4.8); every other element 0; out_vallid high for exactly 8 cycles.
- Extra beat: assert valid for 9 beats with an X 9th row -> the result is identical to the 8-beat case; no X appears on out.
- Negative pivots plus saturation:
  - Stimulus: all elements -4096.
  - Response: the pre-negation path is exercised; saturated outputs are 4095 or -4096 per the golden model.
- Back-to-back matrices: start a second load right after out_vallid falls -> the second result is correct and latency is ≤400 cycles each time.
